// File: rtl/tx_pkt_gen_pkg.sv
// Shared types, constants and helpers for the transmit packet generator.
package tx_pkt_gen_pkg;

    typedef enum logic [1:0] {StIdle = 2'd0, StSend = 2'd1, StGap = 2'd2} state_e;

    // Byte-enable encoding of the last word: number of valid bytes.
    localparam logic [1:0] BeFour  = 2'b00;
    localparam logic [1:0] BeOne   = 2'b01;
    localparam logic [1:0] BeTwo   = 2'b10;
    localparam logic [1:0] BeThree = 2'b11;

    localparam int unsigned MinLenDef = 60;
    localparam int unsigned MaxLenDef = 1514;

    function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] lo,
                                              input logic [15:0] hi);
        if (len < lo) return lo;
        if (len > hi) return hi;
        return len;
    endfunction

    function automatic logic [15:0] ceil_div4(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd3;
        return {1'b0, sum[16:2]};
    endfunction

    function automatic logic [1:0] last_be(input logic [15:0] len);
        logic [1:0] be;
        case (len[1:0])
            2'd1:    be = BeOne;
            2'd2:    be = BeTwo;
            2'd3:    be = BeThree;
            default: be = BeFour;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/tx_word_build.sv
// Combinational frame word builder: header, sequence number and byte-offset pattern,
// with bytes beyond the frame length forced to zero.
module tx_word_build
    import tx_pkt_gen_pkg::*;
#(
    parameter logic [47:0] DA        = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SA        = 48'h0012_3456_789A,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic [15:0] word_idx,
    input  logic [15:0] len,
    input  logic [31:0] seq,
    output logic [31:0] word
);

    logic [15:0] base;

    function automatic logic [7:0] byte_at(input logic [15:0] k, input logic [31:0] s);
        logic [7:0] b;
        if (k < 16'd6)       b = 8'(DA >> (8 * (5 - k)));
        else if (k < 16'd12) b = 8'(SA >> (8 * (11 - k)));
        else if (k < 16'd14) b = 8'(ETHERTYPE >> (8 * (13 - k)));
        else if (k < 16'd18) b = 8'(s >> (8 * (17 - k)));
        else                 b = k[7:0];
        return b;
    endfunction

    assign base = {word_idx[13:0], 2'b00};

    // Big-endian packing: lowest byte offset lands in [31:24].
    always_comb begin
        word = '0;
        for (int j = 0; j < 4; j++) begin
            if (base + 16'(j) < len) word[8*(3-j) +: 8] = byte_at(base + 16'(j), seq);
        end
    end

endmodule

// File: rtl/tx_pkt_gen.sv
// Ethernet frame traffic generator driving the MAC user transmit interface.
// Runs a programmable number of frames separated by a configurable idle gap.
module tx_pkt_gen
    import tx_pkt_gen_pkg::*;
#(
    parameter logic [47:0] DA        = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SA        = 48'h0012_3456_789A,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int unsigned MIN_LEN   = MinLenDef,
    parameter int unsigned MAX_LEN   = MaxLenDef
) (
    input  logic        Clk_user,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Stop,
    input  logic [15:0] Pkt_len,
    input  logic [31:0] Pkt_cnt,
    input  logic [15:0] Ifg_cycles,
    input  logic        Tx_mac_wa,
    output logic        Tx_mac_wr,
    output logic [31:0] Tx_mac_data,
    output logic [1:0]  Tx_mac_BE,
    output logic        Tx_mac_sop,
    output logic        Tx_mac_eop,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Pkts_sent
);

    state_e      state_q;
    logic [15:0] len_q, idx_q, gap_q;
    logic [31:0] seq_q, cnt_q;
    logic        stop_pend_q, more_q;

    logic [15:0] len_in, n_words;
    logic [31:0] word, pkts_inc;
    logic        last_word, more, stop_now;

    assign len_in    = clamp_len(Pkt_len, 16'(MIN_LEN), 16'(MAX_LEN));
    assign n_words   = ceil_div4(len_q);
    assign last_word = (idx_q == n_words - 16'd1);
    assign pkts_inc  = Pkts_sent + 32'd1;
    // A zero frame count means the run only ends on Stop.
    assign more      = (cnt_q == '0) || (pkts_inc != cnt_q);
    assign stop_now  = stop_pend_q || Stop;

    tx_word_build #(
        .DA       (DA),
        .SA       (SA),
        .ETHERTYPE(ETHERTYPE)
    ) u_word_build (
        .word_idx(idx_q),
        .len     (len_q),
        .seq     (seq_q),
        .word    (word)
    );

    always_ff @(posedge Clk_user) begin
        if (Reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            seq_q       <= '0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            more_q      <= 1'b0;
            Tx_mac_wr   <= 1'b0;
            Tx_mac_data <= '0;
            Tx_mac_BE   <= '0;
            Tx_mac_sop  <= 1'b0;
            Tx_mac_eop  <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Pkts_sent   <= '0;
        end else begin
            Tx_mac_wr  <= 1'b0;
            Tx_mac_sop <= 1'b0;
            Tx_mac_eop <= 1'b0;
            Done       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Busy stays high through the Done cycle and drops here.
                    Busy <= 1'b0;
                    if (Start) begin
                        state_q     <= StSend;
                        Busy        <= 1'b1;
                        seq_q       <= '0;
                        Pkts_sent   <= '0;
                        cnt_q       <= Pkt_cnt;
                        len_q       <= len_in;
                        idx_q       <= '0;
                        stop_pend_q <= Stop;
                    end
                end
                StSend: begin
                    if (Stop) stop_pend_q <= 1'b1;
                    if (Tx_mac_wa) begin
                        Tx_mac_wr   <= 1'b1;
                        Tx_mac_data <= word;
                        Tx_mac_sop  <= (idx_q == '0);
                        Tx_mac_eop  <= last_word;
                        Tx_mac_BE   <= last_word ? last_be(len_q) : BeFour;
                        if (last_word) begin
                            idx_q     <= '0;
                            seq_q     <= seq_q + 32'd1;
                            Pkts_sent <= pkts_inc;
                            more_q    <= more;
                            gap_q     <= Ifg_cycles;
                            if (Ifg_cycles != '0) begin
                                state_q <= StGap;
                            end else if (more && !stop_now) begin
                                len_q <= len_in;
                            end else begin
                                state_q <= StIdle;
                                Done    <= 1'b1;
                            end
                        end else begin
                            idx_q <= idx_q + 16'd1;
                        end
                    end
                end
                StGap: begin
                    if (Stop) stop_pend_q <= 1'b1;
                    if (gap_q <= 16'd1) begin
                        if (more_q && !stop_now) begin
                            state_q <= StSend;
                            len_q   <= len_in;
                        end else begin
                            state_q <= StIdle;
                            Done    <= 1'b1;
                        end
                    end else begin
                        gap_q <= gap_q - 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_pkt_gen.sv
// Self-checking bench for tx_pkt_gen against a byte-level frame model.
module tb_tx_pkt_gen;

    localparam logic [47:0] DA_E = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SA_E = 48'h0012_3456_789A;
    localparam logic [15:0] ET_E = 16'h88B5;

    logic        clk = 1'b0;
    logic        Reset = 1'b1, Start = 1'b0, Stop = 1'b0;
    logic [15:0] Pkt_len = 16'd60, Ifg_cycles = 16'd1;
    logic [31:0] Pkt_cnt = 32'd1;
    logic        wa = 1'b0;
    logic        Tx_mac_wr, Tx_mac_sop, Tx_mac_eop, Busy, Done;
    logic [31:0] Tx_mac_data, Pkts_sent;
    logic [1:0]  Tx_mac_BE;

    tx_pkt_gen dut (
        .Clk_user   (clk),
        .Reset      (Reset),
        .Start      (Start),
        .Stop       (Stop),
        .Pkt_len    (Pkt_len),
        .Pkt_cnt    (Pkt_cnt),
        .Ifg_cycles (Ifg_cycles),
        .Tx_mac_wa  (wa),
        .Tx_mac_wr  (Tx_mac_wr),
        .Tx_mac_data(Tx_mac_data),
        .Tx_mac_BE  (Tx_mac_BE),
        .Tx_mac_sop (Tx_mac_sop),
        .Tx_mac_eop (Tx_mac_eop),
        .Busy       (Busy),
        .Done       (Done),
        .Pkts_sent  (Pkts_sent)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  be;
        logic        sop;
        logic        eop;
        int          cyc;
    } rec_t;

    rec_t cap[$];
    int   cyc = 0, sop_cnt = 0, eop_cnt = 0, done_cnt = 0, hs_viol = 0;
    logic wa_prev = 1'b0;
    int   n_cmp = 0, n_bad = 0;
    int   wa_mode = 0, tick = 0;

    // Monitor: capture every written word and flag writes not preceded by wa.
    always @(negedge clk) begin
        if (Tx_mac_wr === 1'b1) begin
            cap.push_back('{data: Tx_mac_data, be: Tx_mac_BE, sop: Tx_mac_sop,
                            eop: Tx_mac_eop, cyc: cyc});
            if (!wa_prev) hs_viol++;
            if (Tx_mac_sop) sop_cnt++;
            if (Tx_mac_eop) eop_cnt++;
        end
        if (Done === 1'b1) done_cnt++;
        wa_prev = wa;
        cyc++;
    end

    // wa driver: 0 = always ready, 1 = 4 on / 4 off, other = random.
    always @(posedge clk) begin
        #1;
        tick++;
        case (wa_mode)
            0:       wa = 1'b1;
            1:       wa = ((tick / 4) % 2) == 0;
            default: wa = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- reference model ----------------
    function automatic int clamp_l(int p);
        if (p < 60) return 60;
        if (p > 1514) return 1514;
        return p;
    endfunction

    function automatic logic [31:0] exp_word(int L, int seq, int w);
        logic [143:0] hdr;
        logic [31:0]  r;
        logic [7:0]   v;
        int           k;
        hdr = {DA_E, SA_E, ET_E, 32'(seq)};
        r = '0;
        for (int b = 0; b < 4; b++) begin
            k = 4 * w + b;
            if (k >= L)      v = 8'h00;
            else if (k < 18) v = hdr[143 - 8*k -: 8];
            else             v = 8'(k);
            r = {r[23:0], v};
        end
        return r;
    endfunction

    // {data, sop, eop, be} expected for word w of a frame.
    function automatic logic [35:0] exp_rec(int L, int seq, int w);
        int   nw;
        logic last;
        nw = (L + 3) / 4;
        last = (w == nw - 1);
        return {exp_word(L, seq, w), w == 0, last, last ? 2'(L % 4) : 2'b00};
    endfunction

    function automatic logic [35:0] got_rec(int i);
        return {cap[i].data, cap[i].sop, cap[i].eop, cap[i].be};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input bit st, input bit sp);
        @(posedge clk);
        #1;
        Start = st;
        Stop  = sp;
        @(posedge clk);
        #1;
        Start = 1'b0;
        Stop  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output logic busy_d);
        ok = 1'b0;
        busy_d = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (Done === 1'b1) begin
                ok = 1'b1;
                busy_d = Busy;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({Tx_mac_wr, Tx_mac_sop, Tx_mac_eop, Tx_mac_BE, Busy, Done} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {Tx_mac_wr, Tx_mac_sop, Tx_mac_eop, Tx_mac_BE, Busy, Done});
        end
        n_cmp++;
        if (Tx_mac_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", Tx_mac_data);
        end
        n_cmp++;
        if (Pkts_sent !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_pkts: got %0d want 0", Pkts_sent);
        end
        @(posedge clk);
        #1 Reset = 1'b0;
    endtask

    task automatic test_single_frame;
        int   base, d0;
        bit   ok;
        logic bd;
        wa_mode = 0;
        base = cap.size();
        d0 = done_cnt;
        Pkt_len = 16'd64; Pkt_cnt = 32'd1; Ifg_cycles = 16'd12;
        pulse(1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (Busy !== 1'b1) begin n_bad++; $display("FAIL busy_rise: got %b want 1", Busy); end
        wait_done(2000, ok, bd);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_done: got timeout want Done"); end
        n_cmp++;
        if (bd !== 1'b1) begin n_bad++; $display("FAIL busy_at_done: got %b want 1", bd); end
        @(negedge clk);
        n_cmp++;
        if (Busy !== 1'b0) begin n_bad++; $display("FAIL busy_fall: got %b want 0", Busy); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (cap.size() - base != 16) begin
            n_bad++;
            $display("FAIL single_words: got %0d want 16", cap.size() - base);
        end else begin
            for (int w = 0; w < 16; w++) begin
                n_cmp++;
                if (got_rec(base + w) !== exp_rec(64, 0, w)) begin
                    n_bad++;
                    $display("FAIL single_w%0d: got %h want %h", w, got_rec(base + w),
                             exp_rec(64, 0, w));
                end
            end
            n_cmp++;
            if ({cap[base].data, cap[base+3].data, cap[base+4].data} !==
                {32'hFFFF_FFFF, 32'h88B5_0000, 32'h0000_1213}) begin
                n_bad++;
                $display("FAIL single_hdr: got %h %h %h want FFFFFFFF 88B50000 00001213",
                         cap[base].data, cap[base+3].data, cap[base+4].data);
            end
        end
        n_cmp++;
        if (Pkts_sent !== 32'd1) begin n_bad++; $display("FAIL single_pkts: got %0d want 1", Pkts_sent); end
        n_cmp++;
        if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL single_donecnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_lengths;
        int   lens[7];
        int   base, L, nw;
        bit   ok;
        logic bd;
        lens[0] = 61; lens[1] = 10; lens[2] = 2000;
        for (int i = 3; i < 7; i++) lens[i] = int'($urandom_range(0, 1700));
        for (int i = 0; i < 7; i++) begin
            wa_mode = (i % 2) * 2;
            L = clamp_l(lens[i]);
            nw = (L + 3) / 4;
            base = cap.size();
            Pkt_len = 16'(lens[i]); Pkt_cnt = 32'd1; Ifg_cycles = 16'd2;
            pulse(1'b1, 1'b0);
            wait_done(5000, ok, bd);
            repeat (2) @(negedge clk);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL len%0d_done: got timeout want Done", lens[i]); end
            n_cmp++;
            if (cap.size() - base != nw) begin
                n_bad++;
                $display("FAIL len%0d_words: got %0d want %0d", lens[i], cap.size() - base, nw);
            end else begin
                for (int w = 0; w < nw; w++) begin
                    n_cmp++;
                    if (got_rec(base + w) !== exp_rec(L, 0, w)) begin
                        n_bad++;
                        $display("FAIL len%0d_w%0d: got %h want %h", lens[i], w,
                                 got_rec(base + w), exp_rec(L, 0, w));
                    end
                end
            end
        end
    endtask

    task automatic test_wa_toggle;
        int   base, L, nw, h0, gap;
        bit   ok;
        logic bd;
        wa_mode = 1;
        L = int'($urandom_range(60, 300));
        nw = (L + 3) / 4;
        base = cap.size();
        h0 = hs_viol;
        Pkt_len = 16'(L); Pkt_cnt = 32'd3; Ifg_cycles = 16'd5;
        pulse(1'b1, 1'b0);
        wait_done(20000, ok, bd);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL toggle_done: got timeout want Done"); end
        n_cmp++;
        if (hs_viol != h0) begin n_bad++; $display("FAIL toggle_handshake: got %0d want 0", hs_viol - h0); end
        n_cmp++;
        if (Pkts_sent !== 32'd3) begin n_bad++; $display("FAIL toggle_pkts: got %0d want 3", Pkts_sent); end
        n_cmp++;
        if (cap.size() - base != 3 * nw) begin
            n_bad++;
            $display("FAIL toggle_words: got %0d want %0d", cap.size() - base, 3 * nw);
        end else begin
            for (int i = 0; i < 3 * nw; i++) begin
                n_cmp++;
                if (got_rec(base + i) !== exp_rec(L, i / nw, i % nw)) begin
                    n_bad++;
                    $display("FAIL toggle_f%0d_w%0d: got %h want %h", i / nw, i % nw,
                             got_rec(base + i), exp_rec(L, i / nw, i % nw));
                end
            end
            for (int f = 1; f < 3; f++) begin
                gap = cap[base + f*nw].cyc - cap[base + f*nw - 1].cyc - 1;
                n_cmp++;
                if (gap < 5) begin n_bad++; $display("FAIL toggle_gap%0d: got %0d want >=5", f, gap); end
            end
        end
    endtask

    task automatic test_stop;
        int   base, L, nw, s0, e0, d0;
        bit   got, ok;
        logic bd;
        wa_mode = 2;
        L = int'($urandom_range(60, 120));
        nw = (L + 3) / 4;
        base = cap.size();
        s0 = sop_cnt; e0 = eop_cnt; d0 = done_cnt;
        Pkt_len = 16'(L); Pkt_cnt = 32'd0; Ifg_cycles = 16'd3;
        pulse(1'b1, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (sop_cnt - s0 >= 8) begin got = 1'b1; break; end
        end
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL stop_reach8: got %0d sops want 8", sop_cnt - s0); end
        repeat (2) @(posedge clk);
        pulse(1'b0, 1'b1);
        wait_done(5000, ok, bd);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL stop_done: got timeout want Done"); end
        n_cmp++;
        if (Pkts_sent !== 32'd8) begin n_bad++; $display("FAIL stop_pkts: got %0d want 8", Pkts_sent); end
        n_cmp++;
        if ({sop_cnt - s0, eop_cnt - e0} != {32'd8, 32'd8}) begin
            n_bad++;
            $display("FAIL stop_frames: got sop %0d eop %0d want 8 8", sop_cnt - s0, eop_cnt - e0);
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL stop_donecnt: got %0d want 1", done_cnt - d0); end
        n_cmp++;
        if (cap.size() - base != 8 * nw) begin
            n_bad++;
            $display("FAIL stop_words: got %0d want %0d", cap.size() - base, 8 * nw);
        end else begin
            for (int i = 0; i < 8 * nw; i++) begin
                n_cmp++;
                if (got_rec(base + i) !== exp_rec(L, i / nw, i % nw)) begin
                    n_bad++;
                    $display("FAIL stop_f%0d_w%0d: got %h want %h", i / nw, i % nw,
                             got_rec(base + i), exp_rec(L, i / nw, i % nw));
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int   base, L, nw, e0;
        bit   ok;
        logic bd;
        wa_mode = 0;
        e0 = eop_cnt;
        Pkt_len = 16'd200; Pkt_cnt = 32'd0; Ifg_cycles = 16'd2;
        pulse(1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1 Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({Tx_mac_wr, Tx_mac_sop, Tx_mac_eop, Tx_mac_BE, Busy, Done, Tx_mac_data, Pkts_sent}
            !== 71'b0) begin
            n_bad++;
            $display("FAIL midreset_outs: got wr%b sop%b eop%b be%b busy%b done%b d=%h n=%0d want 0",
                     Tx_mac_wr, Tx_mac_sop, Tx_mac_eop, Tx_mac_BE, Busy, Done, Tx_mac_data,
                     Pkts_sent);
        end
        @(posedge clk);
        #1 Reset = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (eop_cnt != e0) begin n_bad++; $display("FAIL midreset_eop: got %0d want 0", eop_cnt - e0); end
        L = int'($urandom_range(60, 90));
        nw = (L + 3) / 4;
        base = cap.size();
        Pkt_len = 16'(L); Pkt_cnt = 32'd1;
        pulse(1'b1, 1'b0);
        wait_done(2000, ok, bd);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL midreset_done: got timeout want Done"); end
        n_cmp++;
        if (cap.size() - base != nw) begin
            n_bad++;
            $display("FAIL midreset_words: got %0d want %0d", cap.size() - base, nw);
        end else begin
            for (int w = 0; w < nw; w++) begin
                n_cmp++;
                if (got_rec(base + w) !== exp_rec(L, 0, w)) begin
                    n_bad++;
                    $display("FAIL midreset_w%0d: got %h want %h", w, got_rec(base + w),
                             exp_rec(L, 0, w));
                end
            end
        end
    endtask

    task automatic test_start_stop;
        int   s0, d0;
        bit   ok;
        logic bd;
        wa_mode = 0;
        s0 = sop_cnt; d0 = done_cnt;
        Pkt_len = 16'd60; Pkt_cnt = 32'd0; Ifg_cycles = 16'd4;
        pulse(1'b1, 1'b1);
        wait_done(2000, ok, bd);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL startstop_done: got timeout want Done"); end
        n_cmp++;
        if (sop_cnt - s0 != 1) begin n_bad++; $display("FAIL startstop_frames: got %0d want 1", sop_cnt - s0); end
        n_cmp++;
        if (Pkts_sent !== 32'd1) begin n_bad++; $display("FAIL startstop_pkts: got %0d want 1", Pkts_sent); end
        n_cmp++;
        if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL startstop_donecnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back;
        int   base, d0;
        bit   ok;
        logic bd;
        wa_mode = 0;
        base = cap.size();
        d0 = done_cnt;
        Pkt_len = 16'd60; Pkt_cnt = 32'd2; Ifg_cycles = 16'd0;
        pulse(1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1 Pkt_cnt = 32'd7;
        Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        wait_done(2000, ok, bd);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL b2b_done: got timeout want Done"); end
        n_cmp++;
        if (Pkts_sent !== 32'd2) begin n_bad++; $display("FAIL b2b_pkts: got %0d want 2", Pkts_sent); end
        n_cmp++;
        if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL b2b_donecnt: got %0d want 1", done_cnt - d0); end
        n_cmp++;
        if (cap.size() - base != 30) begin
            n_bad++;
            $display("FAIL b2b_words: got %0d want 30", cap.size() - base);
        end else begin
            for (int i = 0; i < 30; i++) begin
                n_cmp++;
                if (got_rec(base + i) !== exp_rec(60, i / 15, i % 15)) begin
                    n_bad++;
                    $display("FAIL b2b_f%0d_w%0d: got %h want %h", i / 15, i % 15,
                             got_rec(base + i), exp_rec(60, i / 15, i % 15));
                end
            end
            n_cmp++;
            if (cap[base+15].cyc - cap[base+14].cyc != 1) begin
                n_bad++;
                $display("FAIL b2b_adjacent: got %0d cycles want 1",
                         cap[base+15].cyc - cap[base+14].cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_lengths();
        test_wa_toggle();
        test_stop();
        test_reset_mid();
        test_start_stop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #700us;
        $display("FAIL watchdog: got no completion want summary");
        $fatal(1, "watchdog expired");
    end

endmodule
